// File: rtl/gate_vector_cal.sv
// gate_vector_cal: one gate row at a time, y[r] = act(W[r].x + U[r].h + b[r]),
// evaluated with a single shared multiplier (one product per MAC cycle).
// Fixed-point, signed two's-complement, FRAC_BITS fractional bits.
module gate_vector_cal #(
  parameter int DATA_WIDTH     = 16,
  parameter int FRAC_BITS      = 8,
  parameter int INPUT_FEATURES = 3,
  parameter int GRU_UNITS      = 7,
  parameter int N_OUT          = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [1:0]                                 act_mode,
  input  logic [INPUT_FEATURES*DATA_WIDTH-1:0]       i_input_vector_flat,
  input  logic [GRU_UNITS*DATA_WIDTH-1:0]            i_hidden_vector_flat,
  input  logic [N_OUT*INPUT_FEATURES*DATA_WIDTH-1:0] i_W_weights_flat,
  input  logic [N_OUT*GRU_UNITS*DATA_WIDTH-1:0]      i_U_weights_flat,
  input  logic [N_OUT*DATA_WIDTH-1:0]                i_bias_flat,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       sat_flag,
  output logic [N_OUT*DATA_WIDTH-1:0]                gate_result_flat
);
  localparam int DW     = DATA_WIDTH;
  localparam int K      = INPUT_FEATURES + GRU_UNITS;
  localparam int PROD_W = 2 * DW;
  localparam int ACC_W  = 2 * DW + $clog2(K + 1);
  localparam int IDX_W  = $clog2(K + 1);
  localparam int ROW_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW+1:0]    ONE   = {{(DW+1-FRAC_BITS){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
  localparam logic signed [DW+1:0]    HALF  = ONE >>> 1;
  localparam logic signed [DW+1:0]    NONE  = -ONE;

  typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

  state_t                       state_q;
  logic [K-1:0][DW-1:0]         vec_q;     // snapshot {h, x}, x element 0 at index 0
  logic [1:0]                   mode_q;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [IDX_W-1:0]             idx_q;
  logic [ROW_W-1:0]             row_q;
  logic                         busy_q, done_q, sat_q;
  logic [N_OUT-1:0][DW-1:0]     res_q;

  // Weight row for the current gate: W[row] then U[row], aligned with vec_q.
  logic [K-1:0][DW-1:0]         wrow;
  for (genvar k = 0; k < K; k++) begin : g_wrow
    if (k < INPUT_FEATURES) begin : g_w
      assign wrow[k] = i_W_weights_flat[(int'(row_q)*INPUT_FEATURES + k)*DW +: DW];
    end else begin : g_u
      assign wrow[k] = i_U_weights_flat[(int'(row_q)*GRU_UNITS + (k-INPUT_FEATURES))*DW +: DW];
    end
  end

  logic signed [DW-1:0]     a_op, b_op, bias_row, s_val, act_val;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DW+1:0]     s_w, sig, act;
  logic                     clip;

  assign a_op     = vec_q[idx_q];
  assign b_op     = wrow[idx_q];
  assign prod     = a_op * b_op;
  assign bias_row = i_bias_flat[int'(row_q)*DW +: DW];

  // Next accumulator: the first product of each row starts from the scaled bias.
  always_comb begin
    acc_d = ((idx_q == '0) ? {{(ACC_W-DW-FRAC_BITS){bias_row[DW-1]}}, bias_row, {FRAC_BITS{1'b0}}}
                           : acc_q)
          + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  // Rescale, saturate to a data word, then apply the selected activation.
  always_comb begin
    shifted = acc_q >>> FRAC_BITS;
    clip    = 1'b0;
    if (shifted > S_MAX) begin
      s_val = {1'b0, {(DW-1){1'b1}}};
      clip  = 1'b1;
    end else if (shifted < S_MIN) begin
      s_val = {1'b1, {(DW-1){1'b0}}};
      clip  = 1'b1;
    end else begin
      s_val = shifted[DW-1:0];
    end
    s_w = {{2{s_val[DW-1]}}, s_val};
    sig = (s_w >>> 2) + HALF;
    case (mode_q)
      2'd0:    act = sig[DW+1] ? '0 : (sig > ONE) ? ONE : sig;
      2'd1:    act = (s_w > ONE) ? ONE : (s_w < NONE) ? NONE : s_w;
      2'd2:    act = s_w;
      default: act = s_w[DW+1] ? '0 : s_w;
    endcase
    act_val = act[DW-1:0];
  end

  // Control FSM plus datapath registers; reset overrides any run in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      mode_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          vec_q   <= {i_hidden_vector_flat, i_input_vector_flat};
          mode_q  <= act_mode;
          sat_q   <= 1'b0;
          busy_q  <= 1'b1;
          acc_q   <= '0;
          idx_q   <= '0;
          row_q   <= '0;
          state_q <= MAC;
        end
        MAC: begin
          acc_q <= acc_d;
          if (idx_q == IDX_W'(K-1)) begin
            idx_q   <= '0;
            state_q <= ACT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ACT: begin
          res_q[row_q] <= act_val;
          if (clip) sat_q <= 1'b1;
          if (row_q == ROW_W'(N_OUT-1)) begin
            state_q <= DONE;
          end else begin
            row_q   <= row_q + 1'b1;
            state_q <= MAC;
          end
        end
        default: begin  // DONE: one cycle to raise done, then wait for start low
          if (!done_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else if (!start) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign sat_flag         = sat_q;
  assign gate_result_flat = res_q;
endmodule

// File: tb/tb_gate_vector_cal.sv
// Bench for gate_vector_cal: directed vectors plus randomized runs checked
// against an integer-arithmetic model of the gate equations.
module tb_gate_vector_cal;
  localparam int DW = 16, FB = 8, NI = 3, NH = 7, NO = 2, K = NI + NH;
  localparam int LAT = NO * (K + 1) + 1;

  logic                  clk = 1'b0, rst, start;
  logic [1:0]            act_mode;
  logic [NI*DW-1:0]      x_flat;
  logic [NH*DW-1:0]      h_flat;
  logic [NO*NI*DW-1:0]   w_flat;
  logic [NO*NH*DW-1:0]   u_flat;
  logic [NO*DW-1:0]      b_flat;
  logic                  busy, done, sat_flag;
  logic [NO*DW-1:0]      res;

  gate_vector_cal dut (
    .clk(clk), .rst(rst), .start(start), .act_mode(act_mode),
    .i_input_vector_flat(x_flat), .i_hidden_vector_flat(h_flat),
    .i_W_weights_flat(w_flat), .i_U_weights_flat(u_flat), .i_bias_flat(b_flat),
    .busy(busy), .done(done), .sat_flag(sat_flag), .gate_result_flat(res)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int xv[NI], hv[NH], wv[NO][NI], uv[NO][NH], bv[NO];
  logic [DW-1:0] exp_res[NO];
  bit            exp_sat;

  task automatic pack_all();
    for (int i = 0; i < NI; i++) x_flat[i*DW +: DW] = DW'(xv[i]);
    for (int i = 0; i < NH; i++) h_flat[i*DW +: DW] = DW'(hv[i]);
    for (int r = 0; r < NO; r++) begin
      b_flat[r*DW +: DW] = DW'(bv[r]);
      for (int i = 0; i < NI; i++) w_flat[(r*NI+i)*DW +: DW] = DW'(wv[r][i]);
      for (int i = 0; i < NH; i++) u_flat[(r*NH+i)*DW +: DW] = DW'(uv[r][i]);
    end
  endtask

  // Reference: exact dot product, floor-rescale, clip, activation.
  task automatic compute_expect(input int mode);
    longint acc, s, t;
    exp_sat = 0;
    for (int r = 0; r < NO; r++) begin
      acc = longint'(bv[r]) * 256;
      for (int i = 0; i < NI; i++) acc += longint'(xv[i]) * longint'(wv[r][i]);
      for (int i = 0; i < NH; i++) acc += longint'(hv[i]) * longint'(uv[r][i]);
      s = acc >>> FB;
      if (s > 32767) begin s = 32767; exp_sat = 1; end
      if (s < -32768) begin s = -32768; exp_sat = 1; end
      case (mode)
        0: begin t = (s >>> 2) + 128; if (t < 0) t = 0; if (t > 256) t = 256; end
        1: begin t = s; if (t < -256) t = -256; if (t > 256) t = 256; end
        2: t = s;
        default: t = (s < 0) ? 0 : s;
      endcase
      exp_res[r] = DW'(t);
    end
  endtask

  task automatic start_run(input string tag, input int mode);
    act_mode = 2'(mode);
    start    = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_after_accept got %b want 1", tag, busy); end
  endtask

  // Counts edges from the accept to done; optional mid-run disturbance of x/h/start.
  task automatic wait_done(input string tag, input bit disturb);
    int cyc = 0;
    bit got = 0, bad_busy = 0;
    for (int n = 1; n <= LAT + 10 && !got; n++) begin
      @(posedge clk); #1;
      if (disturb && n == 1) begin
        for (int i = 0; i < NI; i++) xv[i] = int'($urandom_range(0, 65535)) - 32768;
        for (int i = 0; i < NH; i++) hv[i] = int'($urandom_range(0, 65535)) - 32768;
        pack_all();
      end
      if (disturb && n == 4) start = 1'b0;
      if (disturb && n == 7) start = 1'b1;
      if (done === 1'b1) begin got = 1; cyc = n; end
      else if (busy !== 1'b1) bad_busy = 1;
    end
    n_cmp++;
    if (cyc != LAT) begin n_bad++; $display("FAIL %s latency got %0d want %0d", tag, cyc, LAT); end
    n_cmp++;
    if (bad_busy || (got && busy !== 1'b0)) begin
      n_bad++; $display("FAIL %s busy_profile got busy=%b at done, gap=%b want 0", tag, busy, bad_busy);
    end
  endtask

  task automatic check_out(input string tag);
    for (int r = 0; r < NO; r++) begin
      n_cmp++;
      if (res[r*DW +: DW] !== exp_res[r]) begin
        n_bad++; $display("FAIL %s row%0d got %h want %h", tag, r, res[r*DW +: DW], exp_res[r]);
      end
    end
    n_cmp++;
    if (sat_flag !== exp_sat) begin n_bad++; $display("FAIL %s sat_flag got %b want %b", tag, sat_flag, exp_sat); end
  endtask

  // Drop start and confirm done falls one edge later while results persist.
  task automatic release_run(input string tag);
    start = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL %s done_fall got %b want 0", tag, done); end
    check_out({tag, "_held"});
  endtask

  task automatic full_run(input string tag, input int mode);
    compute_expect(mode);
    start_run(tag, mode);
    wait_done(tag, 1'b0);
    check_out(tag);
    release_run(tag);
  endtask

  task automatic clear_vecs();
    for (int i = 0; i < NI; i++) xv[i] = 0;
    for (int i = 0; i < NH; i++) hv[i] = 0;
    for (int r = 0; r < NO; r++) begin
      bv[r] = 0;
      for (int i = 0; i < NI; i++) wv[r][i] = 0;
      for (int i = 0; i < NH; i++) uv[r][i] = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; act_mode = 2'd0;
    clear_vecs(); pack_all();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, sat_flag} !== 3'b000 || res !== '0) begin
      n_bad++; $display("FAIL reset_state got busy=%b done=%b sat=%b res=%h want 0", busy, done, sat_flag, res);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    // Zero weights, bias 1.0 -> hard-sigmoid 0.75; also first edge after reset accepts.
    clear_vecs(); bv[0] = 'h100; bv[1] = 'h100; pack_all();
    full_run("sigmoid_bias", 0);
    // 1.5 clipped by hard-tanh, -0.75 passes.
    clear_vecs();
    for (int i = 0; i < NI; i++) begin xv[i] = 'h100; wv[0][i] = 'h80; wv[1][i] = -64; end
    pack_all();
    full_run("tanh_clip", 1);
    // Large positive sum saturates in identity mode.
    clear_vecs();
    for (int i = 0; i < NI; i++) begin xv[i] = 'h7FFF; wv[0][i] = 'h7FFF; wv[1][i] = 'h7FFF; end
    pack_all();
    full_run("ident_sat", 2);
    // ReLU: row0 sum -0.5 -> 0, row1 +0.25 passes; sat_flag cleared by new accept.
    clear_vecs(); bv[0] = -128; bv[1] = 64; pack_all();
    full_run("relu_neg", 3);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int lim = (t % 2 == 0) ? 32768 : 512;
      for (int i = 0; i < NI; i++) xv[i] = int'($urandom_range(0, 2*lim-1)) - lim;
      for (int i = 0; i < NH; i++) hv[i] = int'($urandom_range(0, 2*lim-1)) - lim;
      for (int r = 0; r < NO; r++) begin
        bv[r] = int'($urandom_range(0, 2*lim-1)) - lim;
        for (int i = 0; i < NI; i++) wv[r][i] = int'($urandom_range(0, 2*lim-1)) - lim;
        for (int i = 0; i < NH; i++) uv[r][i] = int'($urandom_range(0, 2*lim-1)) - lim;
      end
      pack_all();
      full_run($sformatf("rand%0d", t), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < NI; i++) xv[i] = 300 + i;
    for (int r = 0; r < NO; r++) bv[r] = 77 + r;
    pack_all();
    start_run("rst_mid", 2);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, sat_flag} !== 3'b000 || res !== '0) begin
      n_bad++; $display("FAIL rst_mid_clear got busy=%b done=%b sat=%b res=%h want 0", busy, done, sat_flag, res);
    end
    rst = 1'b0;
    compute_expect(2);
    start_run("rst_restart", 2);
    wait_done("rst_restart", 1'b0);
    check_out("rst_restart");
    release_run("rst_restart");
  endtask

  task automatic test_isolation();
    for (int i = 0; i < NI; i++) xv[i] = 100 * (i + 1);
    for (int i = 0; i < NH; i++) hv[i] = -50 * i;
    for (int r = 0; r < NO; r++) begin
      bv[r] = 20 - 40 * r;
      for (int i = 0; i < NI; i++) wv[r][i] = 60 + r + i;
      for (int i = 0; i < NH; i++) uv[r][i] = 30 - 7 * i + r;
    end
    pack_all();
    compute_expect(1);
    start_run("isolate", 1);
    wait_done("isolate", 1'b1);
    check_out("isolate");
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b1) begin n_bad++; $display("FAIL isolate_hold%0d done got %b want 1", n, done); end
    end
    release_run("isolate");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NH; i++) hv[i] = 256;
    for (int r = 0; r < NO; r++) for (int i = 0; i < NH; i++) uv[r][i] = 16 * (r + 1);
    pack_all();
    full_run("b2b_a", 0);
    full_run("b2b_b", 3);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_midrun();
    test_isolation();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gate_vector_cal.md
GATE_VECTOR_CAL -- requirements
Module: gate_vector_cal

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed two's-complement fixed-point word width.
REQ-002 SHALL have parameter FRAC_BITS, default 8: fractional bits per word (1.0 = 1<<FRAC_BITS).
REQ-003 SHALL have parameter INPUT_FEATURES, default 3: length of x.
REQ-004 SHALL have parameter GRU_UNITS, default 7: length of h.
REQ-005 SHALL have parameter N_OUT, default 2: gate rows computed per start; K = INPUT_FEATURES+GRU_UNITS.
REQ-006 SHALL have port clk  in  1: single clock; all logic on rising edge.
REQ-007 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-008 SHALL have port start  in  1: level request; accepted only in IDLE.
REQ-009 SHALL have port act_mode  in  2: 0 hard-sigmoid, 1 hard-tanh, 2 identity, 3 ReLU; sampled at accept.
REQ-010 SHALL have port i_input_vector_flat  in  INPUT_FEATURES*DATA_WIDTH: x, element 0 in LSBs.
REQ-011 SHALL have port i_hidden_vector_flat  in  GRU_UNITS*DATA_WIDTH: h, element 0 in LSBs.
REQ-012 SHALL have port i_W_weights_flat  in  N_OUT*INPUT_FEATURES*DATA_WIDTH: row r occupies slice r, row-major.
REQ-013 SHALL have port i_U_weights_flat  in  N_OUT*GRU_UNITS*DATA_WIDTH: row-major as W.
REQ-014 SHALL have port i_bias_flat  in  N_OUT*DATA_WIDTH: per-row bias.
REQ-015 SHALL have port busy  out  1: high from accept until done rises.
REQ-016 SHALL have port done  out  1: completion level.
REQ-017 SHALL have port sat_flag  out  1: sticky per run; any row saturated.
REQ-018 SHALL have port gate_result_flat  out  N_OUT*DATA_WIDTH: activated outputs, row 0 in LSBs.

Function
REQ-019 SHALL implement states IDLE, MAC, ACT, DONE; IDLE->MAC on start; MAC->ACT after K products; ACT->MAC (next row) or ->DONE after row N_OUT-1; DONE->IDLE when start low.
REQ-020 SHALL on accept snapshot x, h and act_mode into internal registers; later input changes do not affect the run; W, U, bias must be held stable by caller until done.
REQ-021 SHALL use one shared multiplier, one product per MAC cycle: x elements first (index 0 up), then h elements.
REQ-022 SHALL accumulate in ACC_W = 2*DATA_WIDTH+clog2(K+1) bits, initialised per row to bias sign-extended and shifted left FRAC_BITS; no intermediate overflow possible.
REQ-023 SHALL in ACT: arithmetic right-shift accumulator by FRAC_BITS (truncate toward -inf), saturate to [-2^(DW-1), 2^(DW-1)-1], set sat_flag if clipped, apply activation, write result slot r.
REQ-024 SHALL compute hard-sigmoid as clamp((s>>>2)+0.5, 0, 1.0); hard-tanh as clamp(s, -1.0, 1.0); identity as s; ReLU as max(s,0).
REQ-025 SHALL raise done exactly N_OUT*(K+1)+1 cycles after the accepting edge; busy low same cycle.
REQ-026 SHALL hold done and gate_result_flat while start stays high; done falls the cycle after start is seen low; result retains value until next accept.
REQ-027 SHALL ignore start while busy; a new run requires start low then high.
REQ-028 SHALL clear sat_flag on accept; gate_result_flat slots are overwritten row by row.

Reset
REQ-029 SHALL on rst, at next edge, force IDLE, busy=0, done=0, sat_flag=0, gate_result_flat=0, accumulator and counters to 0, overriding any in-flight run.
REQ-030 SHALL accept a start on the first edge after rst deasserts.

Verification (DW=16, FRAC=8, IF=3, GU=7, N_OUT=2, K=10)
REQ-031 SHALL verify W=U=0, bias0=bias1=0x0100, mode 0 -> both outputs 0x00C0, done 23 cycles after accept, sat_flag 0.
REQ-032 SHALL verify x=all 0x0100, h=0, W row0=0x0080, row1=0xFFC0, bias 0, mode 1 -> row0 0x0100 (1.5 clipped), row1 0xFF40.
REQ-033 SHALL verify W=0x7FFF, x=0x7FFF, mode 2 -> 0x7FFF, sat_flag 1; mode 3 with row sum -0.5 -> 0x0000.
REQ-034 SHALL verify rst asserted 5 cycles after accept -> next edge done=0, busy=0, results 0; fresh start completes in 23 cycles.
REQ-035 SHALL verify x changed 1 cycle after accept and start pulsed mid-run -> results unchanged, no restart; start held high after done keeps done high.
